// File: rtl/alu_overflow_seq.sv
// Sequential execute-stage ALU: single-cycle add/sub/slt/logic ops with a
// gated signed-overflow flag and a sticky status bit, plus an iterative
// shift-add multiply producing HI:LO behind a start/busy/done handshake.
module alu_overflow_seq #(
    parameter int WIDTH              = 32,
    parameter bit MUL_SIGNED_DEFAULT = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             trap_en,
    input  logic             ovf_clear,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             overflow_sticky
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;

    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = $clog2(WIDTH);
    // The first shift-add step happens on the launch edge, so the MUL state
    // only needs WIDTH-1 further steps, counted 0 .. WIDTH-2.
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed overflow on add: same operand signs, result sign differs.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // Signed overflow on sub: operand signs differ, result sign differs from a.
    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    // Magnitude of a two's complement value; the most-negative value maps to
    // 2^(WIDTH-1), which is representable as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    // One shift-add step on {upper, multiplier} with carry kept in the shift.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                   input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] upper;
        upper = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        return {upper, p[WIDTH-1:1]};
    endfunction

    // Restore the product sign when the signed operands had opposite signs.
    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                     input logic               neg);
        return neg ? (~p + (2*WIDTH)'(1)) : p;
    endfunction

    state_t                 state;
    logic [CNT_W-1:0]       count;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]       sum;
    logic [WIDTH-1:0]       diff;
    logic [WIDTH-1:0]       alu_res;
    logic                   alu_ovf;
    logic                   is_mul;
    logic                   mul_sgn;
    logic                   neg_a;
    logic                   neg_b;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;

    logic [WIDTH-1:0]       res_p0;
    logic                   ovf_p0;
    logic                   mul_p0;
    logic                   neg_p0;
    logic [WIDTH-1:0]       mcand_p0;
    logic [2*WIDTH-1:0]     prod_p0;
    logic [2*WIDTH-1:0]     prod_final;

    assign a_s        = a;
    assign b_s        = b;
    assign sum        = a + b;
    assign diff       = a - b;
    assign neg_a      = mul_sgn & a[MSB];
    assign neg_b      = mul_sgn & b[MSB];
    assign mag_a      = mag(a, neg_a);
    assign mag_b      = mag(b, neg_b);
    assign prod_final = apply_sign(prod_p0, neg_p0);

    // Single-cycle ALU and overflow detection on the live operands.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        is_mul  = 1'b0;
        mul_sgn = 1'b0;
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_NOR: alu_res = ~(a | b);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = trap_en && add_ovf(a[MSB], b[MSB], sum[MSB]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = trap_en && sub_ovf(a[MSB], b[MSB], diff[MSB]);
            end
            OP_SLT: alu_res = (a_s < b_s) ? WIDTH'(1) : '0;
            OP_MULT: begin
                is_mul  = 1'b1;
                mul_sgn = MUL_SIGNED_DEFAULT;
            end
            OP_MULTU: is_mul = 1'b1;
            default: alu_res = '0;
        endcase
    end

    // p0: operand capture at launch and iterative multiply accumulation.
    always_ff @(posedge clock) begin
        case (state)
            IDLE: begin
                if (start) begin
                    mul_p0 <= is_mul;
                    res_p0 <= alu_res;
                    ovf_p0 <= alu_ovf;
                    if (is_mul) begin
                        mcand_p0 <= mag_a;
                        neg_p0   <= neg_a ^ neg_b;
                        prod_p0  <= mul_step({{WIDTH{1'b0}}, mag_b}, mag_a);
                    end
                end
            end
            MUL: prod_p0 <= mul_step(prod_p0, mcand_p0);
            default: ;
        endcase
    end

    // Control FSM with registered handshake, result and overflow outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            count           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            result          <= '0;
            hi              <= '0;
            zero            <= 1'b0;
            overflow        <= 1'b0;
            overflow_sticky <= 1'b0;
        end else begin
            done     <= 1'b0;
            overflow <= 1'b0;
            if (ovf_clear) begin
                overflow_sticky <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            count <= '0;
                            busy  <= 1'b1;
                            state <= MUL;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                MUL: begin
                    if (count == LAST_STEP) begin
                        state <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (mul_p0) begin
                        hi     <= prod_final[2*WIDTH-1:WIDTH];
                        result <= prod_final[WIDTH-1:0];
                        zero   <= (prod_final == '0);
                    end else begin
                        result   <= res_p0;
                        zero     <= (res_p0 == '0);
                        overflow <= ovf_p0;
                        // Set wins over a simultaneous clear.
                        if (ovf_p0) begin
                            overflow_sticky <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_overflow_seq.md
Name: alu_overflow_seq

Overview:
- Parametrised, clocked successor to the combinational overflow checker in the execute stage.
- Performs add/sub/slt/nor/and/or in one cycle and signed/unsigned multiply iteratively, producing HI:LO.
- Flags signed overflow with a correct sign-bit rule, gated by the trap-enable input, and keeps a sticky overflow status for the exception logic.
- Sits between ID/EX operand registers and the EX/MEM writeback path; uses a start/busy/done handshake so the pipeline can stall on multiply.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- MUL_SIGNED_DEFAULT, 1, multiply signedness used for op 4'b1000; op 4'b1001 is always unsigned.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch operation; sampled only while busy=0.
- op  in  4  0010 add, 0110 sub, 0111 slt, 1100 nor, 0000 and, 0001 or, 1000 mult, 1001 multu.
- a  in  WIDTH  operand A (two's complement when signed).
- b  in  WIDTH  operand B.
- trap_en  in  1  overflow may raise exception (add/sub only; addu/subu drive 0).
- ovf_clear  in  1  clears overflow_sticky.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse: result/hi/zero/overflow valid.
- result  out  WIDTH  ALU result, or LO for multiply.
- hi  out  WIDTH  HI of last multiply; held across non-multiply ops.
- zero  out  1  result==0 (multiply: {hi,result}==0).
- overflow  out  1  pulses with done when overflow detected and trap_en=1.
- overflow_sticky  out  1  set by any overflow pulse, held until ovf_clear.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; any in-flight multiply is abandoned with no done.
- FSM states:
  - IDLE: start with a single-cycle op computes at that edge and moves to DONE. start with mult/multu latches operands and moves to MUL with count=0.
  - MUL: one shift-add step per cycle; exits to DONE after exactly WIDTH steps.
  - DONE: asserts done for exactly one cycle, then returns to IDLE.
- Handshake and latency:
  - Single-cycle op: start at edge k gives done=1 in the cycle after edge k+1.
  - Multiply: busy=1 for WIDTH cycles, then done.
  - start is ignored while busy=1 or in DONE; no queueing.
  - result, hi and zero hold their values until the next completion.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH.
  - slt compares signed and returns 1 or 0, zero-extended.
  - nor = ~(a|b).
  - Unknown op: result=0, zero=1, overflow=0, latency 1.
- Overflow rule:
  - add: a[msb]==b[msb] and r[msb]!=a[msb].
  - sub: a[msb]!=b[msb] and r[msb]!=a[msb].
  - overflow=rule&&trap_en. Never asserted for slt/logic/multiply.
  - On overflow, result still carries the wrapped value; writeback suppression is the consumer's job.
- Multiply:
  - Signed: magnitudes are multiplied unsigned, and the 2*WIDTH product is negated if the operand signs differ. The most-negative operand is handled correctly (magnitude 2^(WIDTH-1) fits as unsigned).
  - Output: {hi,result}=product.
- Sticky flag: set on an overflow pulse, cleared by ovf_clear. If both happen in the same cycle, set wins. ovf_clear does not affect other outputs.
- Operands are captured at start; changes on a/b during MUL have no effect.

Test Plan:
- add 0x7FFFFFFF+0x00000001, trap_en=1 -> done 1 cycle later, result=0x80000000, overflow=1, sticky=1.
- sub a=0, b=0x80000000, trap_en=1 -> result=0x80000000, overflow=1. The same with trap_en=0 -> overflow=0, sticky unchanged.
- mult a=0xFFFFFFFF (-1), b=0x80000000 -> busy for 32 cycles, done at cycle 33, hi=0x00000000, result=0x80000000, zero=0. The same operands with multu -> hi=0x7FFFFFFF, result=0x80000000.
- start pulsed repeatedly during a multiply with add operands -> ignored; only one done, carrying the multiply result.
- reset asserted at MUL cycle 10 -> busy=0 and all outputs 0 next cycle, no done. A fresh add 2+3 then returns 5 with zero=0.
- Overflow pulse coincident with ovf_clear -> sticky=1. A following cycle with ovf_clear=1 alone -> sticky=0. slt 0xFFFFFFFF<1 -> result=1; nor 0,0 -> 0xFFFFFFFF.
